pipelined_control_unit: RTL and testbench

Pipelined control unit for the 5-stage MIPS-DLX core. It decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall and bubble), resolves BEQ/BNE in MEM (flush and PC select), and keeps saturating stall and flush counters. It sits between the IF/ID register and the datapath pipeline registers, and replaces the purely combinational decoder.

---
 rtl/pipelined_control_unit_pkg.sv | 50 +++++
 rtl/control_decoder.sv | 86 ++++++++
 rtl/pipelined_control_unit.sv | 171 +++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit_pkg
//
// Shared definitions for the pipelined control unit of the 5-stage MIPS-DLX
// core: opcode values, control bundle widths and the bit positions of every
// named control signal inside the EX, M and WB bundles.
//
// Bundle layouts (MSB first):
//   ex : {RegDst, ALUSrc, ALUOp[1:0]}
//   m  : {MemRead, MemWrite, Branch, BOP}
//   wb : {RegWrite, WbSelAlu}
// ---------------------------------------------------------------------------
package pipelined_control_unit_pkg;

    // Opcodes recognised by the decoder (6-bit MIPS primary opcode field).
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    // Bundle widths.
    localparam int EX_W = 4;
    localparam int M_W  = 4;
    localparam int WB_W = 2;

    // EX bundle bit positions.
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 2;
    localparam int EX_ALUOP_LO = 0;

    // ALUOp encodings carried in the EX bundle.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    // M bundle bit positions.
    localparam int M_MEMREAD  = 3;
    localparam int M_MEMWRITE = 2;
    localparam int M_BRANCH   = 1;
    localparam int M_BOP      = 0;

    // WB bundle bit positions.
    localparam int WB_REGWRITE = 1;
    localparam int WB_WBSEL    = 0;

endpackage

// File: rtl/control_decoder.sv
// ---------------------------------------------------------------------------
// control_decoder
//
// Purely combinational decode of the ID-stage opcode into the EX, M and WB
// control bundles, plus a flag telling the hazard logic whether the
// instruction actually reads its rt field.
//
// Parameters:
//   OPC_W       opcode width
//   SUPPORT_IMM 1 = decode ADDI, 0 = treat ADDI as a NOP
//
// Ports:
//   opcode   in   OPC_W  opcode in ID
//   valid    in   1      IF/ID holds a real instruction
//   ex       out  4      {RegDst, ALUSrc, ALUOp[1:0]}
//   m        out  4      {MemRead, MemWrite, Branch, BOP}
//   wb       out  2      {RegWrite, WbSelAlu}
//   uses_rt  out  1      instruction sources rt (R-type, SW, BEQ, BNE)
// ---------------------------------------------------------------------------
module control_decoder
    import pipelined_control_unit_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int SUPPORT_IMM = 1
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic             valid,
    output logic [3:0]       ex,
    output logic [3:0]       m,
    output logic [1:0]       wb,
    output logic             uses_rt
);

    // Opcode decode. Every output starts at zero so unknown opcodes and
    // bubbles (valid low) become a clean NOP with no X bits; each case arm
    // then raises only the control bits its instruction needs.
    always_comb begin
        ex      = '0;
        m       = '0;
        wb      = '0;
        uses_rt = 1'b0;
        if (valid) begin
            case (opcode)
                OPC_W'(OP_LW): begin
                    ex[EX_ALUSRC]    = 1'b1;
                    m[M_MEMREAD]     = 1'b1;
                    wb[WB_REGWRITE]  = 1'b1;
                end
                OPC_W'(OP_SW): begin
                    ex[EX_ALUSRC]    = 1'b1;
                    m[M_MEMWRITE]    = 1'b1;
                    uses_rt          = 1'b1;
                end
                OPC_W'(OP_BEQ): begin
                    ex[EX_ALUOP_LO +: 2] = ALUOP_BRANCH;
                    m[M_BRANCH]          = 1'b1;
                    m[M_BOP]             = 1'b1;
                    uses_rt              = 1'b1;
                end
                OPC_W'(OP_BNE): begin
                    ex[EX_ALUOP_LO +: 2] = ALUOP_BRANCH;
                    m[M_BRANCH]          = 1'b1;
                    uses_rt              = 1'b1;
                end
                OPC_W'(OP_RTYPE): begin
                    ex[EX_REGDST]        = 1'b1;
                    ex[EX_ALUOP_LO +: 2] = ALUOP_RTYPE;
                    wb[WB_REGWRITE]      = 1'b1;
                    wb[WB_WBSEL]         = 1'b1;
                    uses_rt              = 1'b1;
                end
                OPC_W'(OP_ADDI): begin
                    if (SUPPORT_IMM != 0) begin
                        ex[EX_ALUSRC]        = 1'b1;
                        ex[EX_ALUOP_LO +: 2] = ALUOP_ADD;
                        wb[WB_REGWRITE]      = 1'b1;
                        wb[WB_WBSEL]         = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//
// Decodes the ID-stage opcode and carries the resulting control bundles
// through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards
// (stall + bubble), resolves BEQ/BNE in MEM (flush + PC select), and keeps
// saturating stall and flush counters.
//
// Parameters:
//   OPC_W, REG_W   opcode / register address widths
//   SUPPORT_IMM    1 = ADDI decoded, 0 = ADDI is a NOP
//   CNT_W          width of the event counters
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_id_valid     IF/ID holds a real instruction
//   opcode_id       opcode in ID
//   rs_id, rt_id    source register fields in ID
//   zero_mem        ALU zero flag registered in EX/MEM
//   ex_control      ID/EX bundle {RegDst, ALUSrc, ALUOp[1:0]}
//   m_control_mem   EX/MEM bundle {MemRead, MemWrite, Branch, BOP}
//   wb_control_wb   MEM/WB bundle {RegWrite, WbSelAlu}
//   stall           hold PC and IF/ID this cycle
//   flush_if_id     clear IF/ID at the next edge
//   pc_src          select the branch target
//   stall_count     saturating count of stall cycles
//   flush_count     saturating count of taken branches
// ---------------------------------------------------------------------------
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int REG_W       = 5,
    parameter int SUPPORT_IMM = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid,
    input  logic [OPC_W-1:0] opcode_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             zero_mem,
    output logic [3:0]       ex_control,
    output logic [3:0]       m_control_mem,
    output logic [1:0]       wb_control_wb,
    output logic             stall,
    output logic             flush_if_id,
    output logic             pc_src,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Decoded ID-stage bundles.
    logic [EX_W-1:0]  dec_ex;
    logic [M_W-1:0]   dec_m;
    logic [WB_W-1:0]  dec_wb;
    logic             dec_uses_rt;

    // ID/EX register.
    logic [EX_W-1:0]  id_ex_ex;
    logic [M_W-1:0]   id_ex_m;
    logic [WB_W-1:0]  id_ex_wb;
    logic [REG_W-1:0] rt_ex;

    // EX/MEM register.
    logic [M_W-1:0]   ex_mem_m;
    logic [WB_W-1:0]  ex_mem_wb;

    // MEM/WB register.
    logic [WB_W-1:0]  mem_wb_wb;

    logic             load_use;
    logic             branch_taken;

    control_decoder #(
        .OPC_W       (OPC_W),
        .SUPPORT_IMM (SUPPORT_IMM)
    ) u_decoder (
        .opcode  (opcode_id),
        .valid   (if_id_valid),
        .ex      (dec_ex),
        .m       (dec_m),
        .wb      (dec_wb),
        .uses_rt (dec_uses_rt)
    );

    // Hazard and branch resolution. A branch in MEM is taken when the zero
    // flag matches BOP (BEQ wants zero, BNE wants non-zero). A load in EX
    // whose destination feeds the ID instruction needs one bubble; r0 is
    // hard-wired so it never creates a dependency, and rt only matters for
    // instructions that actually read it. A taken branch throws away the
    // ID instruction anyway, so it suppresses the stall.
    always_comb begin
        branch_taken = ex_mem_m[M_BRANCH] & (zero_mem == ex_mem_m[M_BOP]);
        load_use     = id_ex_m[M_MEMREAD] & if_id_valid & (rt_ex != '0) &
                       ((rt_ex == rs_id) | (dec_uses_rt & (rt_ex == rt_id)));
        pc_src       = branch_taken;
        flush_if_id  = branch_taken;
        stall        = load_use & ~branch_taken;
    end

    // Pipeline registers. A taken branch squashes the two younger
    // instructions sitting in ID/EX and EX/MEM; MEM/WB still advances since
    // the branch itself carries an all-zero WB bundle. A load-use stall
    // inserts a bubble into ID/EX only, letting the load move on so the
    // stall resolves after exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_ex  <= '0;
            id_ex_m   <= '0;
            id_ex_wb  <= '0;
            rt_ex     <= '0;
            ex_mem_m  <= '0;
            ex_mem_wb <= '0;
            mem_wb_wb <= '0;
        end else begin
            if (branch_taken) begin
                id_ex_ex  <= '0;
                id_ex_m   <= '0;
                id_ex_wb  <= '0;
                rt_ex     <= '0;
                ex_mem_m  <= '0;
                ex_mem_wb <= '0;
            end else if (load_use) begin
                id_ex_ex  <= '0;
                id_ex_m   <= '0;
                id_ex_wb  <= '0;
                rt_ex     <= '0;
                ex_mem_m  <= id_ex_m;
                ex_mem_wb <= id_ex_wb;
            end else begin
                id_ex_ex  <= dec_ex;
                id_ex_m   <= dec_m;
                id_ex_wb  <= dec_wb;
                rt_ex     <= rt_id;
                ex_mem_m  <= id_ex_m;
                ex_mem_wb <= id_ex_wb;
            end
            mem_wb_wb <= ex_mem_wb;
        end
    end

    // Performance counters. Each one holds at its maximum instead of
    // wrapping so a long run never reports a misleadingly small count.
    // Only real stalls are counted; a load-use masked by a taken branch
    // shows up as a flush alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_taken && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    // Bundle outputs come straight from the stage registers they belong to.
    always_comb begin
        ex_control    = id_ex_ex;
        m_control_mem = ex_mem_m;
        wb_control_wb = mem_wb_wb;
    end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
//
// Directed bench for pipelined_control_unit. A default-parameter instance
// runs a table of one-cycle vectors with hand-computed expectations; a
// second instance (CNT_W=2, SUPPORT_IMM=0) shares the same stimulus and is
// checked for counter saturation and ADDI-as-NOP decode.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;

    logic        clk;
    logic        rst;
    logic        if_id_valid;
    logic [5:0]  opcode_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        zero_mem;

    logic [3:0]  ex_control;
    logic [3:0]  m_control_mem;
    logic [1:0]  wb_control_wb;
    logic        stall;
    logic        flush_if_id;
    logic        pc_src;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    logic [3:0]  ex_control2;
    logic [3:0]  m_control_mem2;
    logic [1:0]  wb_control_wb2;
    logic        stall2;
    logic        flush_if_id2;
    logic        pc_src2;
    logic [1:0]  stall_count2;
    logic [1:0]  flush_count2;

    int checks;
    int failures;

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       z;
        logic [3:0] ex;
        logic [3:0] m;
        logic [1:0] wb;
        logic       st;
        logic       fl;
        logic       pc;
        int         sc;
        int         fc;
    } vec_t;

    vec_t vecs[$];

    pipelined_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_valid   (if_id_valid),
        .opcode_id     (opcode_id),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .zero_mem      (zero_mem),
        .ex_control    (ex_control),
        .m_control_mem (m_control_mem),
        .wb_control_wb (wb_control_wb),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .pc_src        (pc_src),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    pipelined_control_unit #(
        .CNT_W       (2),
        .SUPPORT_IMM (0)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .if_id_valid   (if_id_valid),
        .opcode_id     (opcode_id),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .zero_mem      (zero_mem),
        .ex_control    (ex_control2),
        .m_control_mem (m_control_mem2),
        .wb_control_wb (wb_control_wb2),
        .stall         (stall2),
        .flush_if_id   (flush_if_id2),
        .pc_src        (pc_src2),
        .stall_count   (stall_count2),
        .flush_count   (flush_count2)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic z, logic [3:0] ex, logic [3:0] m, logic [1:0] wb,
                                logic st, logic fl, logic pc, int sc, int fc);
        vec_t t;
        t.v = v;   t.op = op; t.rs = rs; t.rt = rt; t.z = z;
        t.ex = ex; t.m = m;   t.wb = wb;
        t.st = st; t.fl = fl; t.pc = pc; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    // Drive one cycle's ID/MEM inputs at the falling edge, then let the
    // combinational outputs settle before anything is sampled.
    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic z);
        @(negedge clk);
        rst         = 1'b0;
        if_id_valid = v;
        opcode_id   = op;
        rs_id       = rs;
        rt_id       = rt;
        zero_mem    = z;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        if_id_valid = 1'b0;
        opcode_id   = '0;
        rs_id       = '0;
        rt_id       = '0;
        zero_mem    = 1'b0;

        //                 v  op    rs rt z  ex       m        wb     st fl pc sc fc
        vecs.push_back(mk(1, R,    1, 2, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0)); // reset state
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LW,   1, 5, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, R,    5, 3, 0, 4'b0100, 4'b0000, 2'b00, 1, 0, 0, 0, 0)); // load-use
        vecs.push_back(mk(1, R,    5, 3, 0, 4'b0000, 4'b1000, 2'b00, 0, 0, 0, 1, 0)); // bubble
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b1010, 4'b0000, 2'b10, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, LW,   0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, R,    0, 0, 0, 4'b0100, 4'b0000, 2'b11, 0, 0, 0, 1, 0)); // r0 no stall
        vecs.push_back(mk(1, LW,   1, 7, 0, 4'b1010, 4'b1000, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, ADDI, 2, 7, 0, 4'b0100, 4'b0000, 2'b10, 0, 0, 0, 1, 0)); // rt unused
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0100, 4'b1000, 2'b11, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0000, 4'b0000, 2'b10, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, BEQ,  1, 2, 0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, SW,   1, 2, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, R,    3, 4, 1, 4'b0100, 4'b0011, 2'b00, 0, 1, 1, 1, 0)); // BEQ taken
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 1)); // squashed
        vecs.push_back(mk(1, BNE,  1, 2, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, R,    0, 0, 1, 4'b0000, 4'b0010, 2'b00, 0, 0, 0, 1, 1)); // BNE not taken
        vecs.push_back(mk(1, BNE,  1, 2, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, LW,   1, 6, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, R,    6, 1, 0, 4'b0100, 4'b0010, 2'b00, 0, 1, 1, 1, 1)); // flush beats stall
        vecs.push_back(mk(0, R,    0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 1, 2));

        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].z);
            checkOutput($sformatf("v%0d ex_control", i),    32'(ex_control),    32'(vecs[i].ex));
            checkOutput($sformatf("v%0d m_control_mem", i), 32'(m_control_mem), 32'(vecs[i].m));
            checkOutput($sformatf("v%0d wb_control_wb", i), 32'(wb_control_wb), 32'(vecs[i].wb));
            checkOutput($sformatf("v%0d stall", i),         32'(stall),         32'(vecs[i].st));
            checkOutput($sformatf("v%0d flush_if_id", i),   32'(flush_if_id),   32'(vecs[i].fl));
            checkOutput($sformatf("v%0d pc_src", i),        32'(pc_src),        32'(vecs[i].pc));
            checkOutput($sformatf("v%0d stall_count", i),   32'(stall_count),   32'(vecs[i].sc));
            checkOutput($sformatf("v%0d flush_count", i),   32'(flush_count),   32'(vecs[i].fc));
        end

        // Five back-to-back load-use pairs: the 16-bit counter reaches 6
        // while the 2-bit counter (already at 1) must stick at 3.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, LW, 5'd1, 5'd5, 1'b0);
            checkOutput($sformatf("sat%0d stall before", k), 32'(stall), 32'd0);
            applyStimulus(1'b1, R, 5'd5, 5'd3, 1'b0);
            checkOutput($sformatf("sat%0d stall", k), 32'(stall), 32'd1);
            applyStimulus(1'b1, R, 5'd5, 5'd3, 1'b0);
            checkOutput($sformatf("sat%0d stall released", k), 32'(stall), 32'd0);
        end
        applyStimulus(1'b0, R, 5'd0, 5'd0, 1'b0);
        checkOutput("sat stall_count wide", 32'(stall_count),  32'd6);
        checkOutput("sat stall_count 2bit", 32'(stall_count2), 32'd3);
        checkOutput("sat flush_count 2bit", 32'(flush_count2), 32'd2);

        // ADDI with immediate support disabled decodes as a NOP.
        applyStimulus(1'b1, ADDI, 5'd2, 5'd3, 1'b0);
        applyStimulus(1'b0, R, 5'd0, 5'd0, 1'b0);
        checkOutput("addi ex imm on",  32'(ex_control),  32'b0100);
        checkOutput("addi ex imm off", 32'(ex_control2), 32'b0000);
        applyStimulus(1'b0, R, 5'd0, 5'd0, 1'b0);
        checkOutput("addi m imm off",  32'(m_control_mem2), 32'b0000);
        applyStimulus(1'b0, R, 5'd0, 5'd0, 1'b0);
        checkOutput("addi wb imm on",  32'(wb_control_wb),  32'b11);
        checkOutput("addi wb imm off", 32'(wb_control_wb2), 32'b00);

        // Reset asserted while a load-use stall is pending wins at that edge.
        applyStimulus(1'b1, LW, 5'd1, 5'd5, 1'b0);
        applyStimulus(1'b1, R, 5'd5, 5'd3, 1'b0);
        checkOutput("rst-stall stall pending", 32'(stall), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, R, 5'd0, 5'd0, 1'b0);
        checkOutput("rst-stall ex_control",  32'(ex_control),    32'b0000);
        checkOutput("rst-stall m_control",   32'(m_control_mem), 32'b0000);
        checkOutput("rst-stall stall",       32'(stall),         32'd0);
        checkOutput("rst-stall pc_src",      32'(pc_src),        32'd0);
        checkOutput("rst-stall stall_count", 32'(stall_count),   32'd0);
        checkOutput("rst-stall flush_count", 32'(flush_count),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
